// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, legal ranges for the
// frame-format parameters, and the FIFO occupancy width. Kept separate so a
// receiver can reuse the same state names and limits.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 8;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // Occupancy width: holds 0..16 for the deepest supported FIFO.
  localparam int COUNT_W = 5;

  // Pulls an out-of-range frame parameter back into its legal range.
  function automatic int clamp_int(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte handshake between a producer and the UART transmitter.
//   TX_DATA  : byte to send
//   TX_VALID : push request
//   TX_READY : transmitter FIFO has room; a push happens when both are high
// master = producer side, slave = transmitter side.
interface uart_transmitter_if;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;

  modport master (output TX_DATA, output TX_VALID, input  TX_READY);
  modport slave  (input  TX_DATA, input  TX_VALID, output TX_READY);
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO for the UART transmitter.
//   CLK, RESET : clock, asynchronous active-high reset
//   push, din  : write request and data (ignored while full)
//   pop, dout  : read request (ignored while empty) and head-of-queue data
//   count      : occupancy, full / empty decoded from it
// FIFO_DEPTH must be a power of two so the pointers wrap on their own.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               push,
  input  logic               pop,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               do_push, do_pop;

  // NOTE: every signal gets its default before any branch so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    full     = (count_q == COUNT_W'(FIFO_DEPTH));
    empty    = (count_q == '0);
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + COUNT_W'(1);
    if (do_pop && !do_push) count_d = count_q - COUNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are only visible
  // through entries the pointers mark as valid, so clearing it buys nothing.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter with a small transmit FIFO.
//   CLK, RESET : system clock, asynchronous active-high reset
//   BCLK       : baud square wave in the CLK domain, one period per bit
//   tx         : byte handshake (TX_DATA / TX_VALID / TX_READY)
//   TXD        : serial line, idle high, registered
//   BUSY       : frame in progress or bytes still queued
//   FIFO_COUNT : FIFO occupancy
// Frame: start(0), DATA_BITS LSB first, optional parity, STOP_BITS of 1.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               BCLK,
  uart_transmitter_if.slave  tx,
  output logic               TXD,
  output logic               BUSY,
  output logic [COUNT_W-1:0] FIFO_COUNT
);

  localparam int         DBITS     = clamp_int(DATA_BITS, DATA_BITS_MIN, DATA_BITS_MAX);
  localparam int         SBITS     = clamp_int(STOP_BITS, STOP_BITS_MIN, STOP_BITS_MAX);
  localparam logic [7:0] DATA_MASK = 8'((1 << DBITS) - 1);
  localparam logic       ODD_BIT   = (PARITY_ODD != 0);

  tx_state_t          state_q, state_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic               stop_cnt_q, stop_cnt_d;
  logic               parity_q, parity_d;
  logic               txd_q, txd_d;
  logic               bclk_q;
  logic               strobe;
  logic               start_frame;
  logic               fifo_pop;
  logic [7:0]         fifo_dout;
  logic               fifo_full, fifo_empty;
  logic [COUNT_W-1:0] fifo_count;

  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (tx.TX_VALID),
    .pop   (fifo_pop),
    .din   (tx.TX_DATA),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // One-cycle pulse on each rising edge of the baud square wave.
  assign strobe = BCLK & ~bclk_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    parity_d    = parity_q;
    txd_d       = txd_q;
    start_frame = 1'b0;
    fifo_pop    = 1'b0;

    if (strobe) begin
      unique case (state_q)
        IDLE: start_frame = ~fifo_empty;
        START: begin
          state_d   = DATA;
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = 3'd0;
        end
        DATA: begin
          if (bit_cnt_q == 3'(DBITS - 1)) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              txd_d   = parity_q;
            end else begin
              state_d    = STOP;
              txd_d      = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
        PARITY: begin
          state_d    = STOP;
          txd_d      = 1'b1;
          stop_cnt_d = 1'b0;
        end
        STOP: begin
          if (stop_cnt_q == 1'(SBITS - 1)) begin
            // Chain straight into the next start bit when more data waits.
            if (!fifo_empty) begin
              start_frame = 1'b1;
            end else begin
              state_d = IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          txd_d   = 1'b1;
        end
      endcase
    end

    // Capture the head byte once; later TX_DATA activity cannot reach it.
    if (start_frame) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_dout & DATA_MASK;
      parity_d = (^(fifo_dout & DATA_MASK)) ^ ODD_BIT;
      state_d  = START;
      txd_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      txd_q      <= 1'b1;
      bclk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      txd_q      <= txd_d;
      bclk_q     <= BCLK;
    end
  end

  assign TXD         = txd_q;
  assign BUSY        = (state_q != IDLE) | ~fifo_empty;
  assign FIFO_COUNT  = fifo_count;
  assign tx.TX_READY = ~fifo_full;

endmodule
